// File: rtl/alarma_pkg.sv
// Shared types for the timed vehicle alarm controller.
// Holds the 2-bit FSM state encoding used by the top and by the bench.
package alarma_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        ESPERA   = 2'd1,
        ALARMA   = 2'd2,
        SILENCIO = 2'd3
    } estado_t;

endpackage

// File: rtl/alarma_temporizada_if.sv
// Sensor/actuator bundle of the timed vehicle alarm.
//   sLuz, sPrta[N_PUERTAS], sIgn, sAck : sensor and user inputs (driven by master)
//   sAlr, sPrtaCap[N_PUERTAS], estado  : registered alarm outputs (driven by slave)
// master = sensor side / environment, slave = alarm controller.
interface alarma_temporizada_if #(
    parameter int N_PUERTAS = 4
) ();

    logic                 sLuz;
    logic [N_PUERTAS-1:0] sPrta;
    logic                 sIgn;
    logic                 sAck;
    logic                 sAlr;
    logic [N_PUERTAS-1:0] sPrtaCap;
    logic [1:0]           estado;

    modport master (
        output sLuz, sPrta, sIgn, sAck,
        input  sAlr, sPrtaCap, estado
    );

    modport slave (
        input  sLuz, sPrta, sIgn, sAck,
        output sAlr, sPrtaCap, estado
    );

endinterface

// File: rtl/alarma_temporizada_contador_retardo.sv
// Saturating up-counter with terminal-count flag.
//   clk, reset : clock, synchronous active-high reset
//   clr        : synchronous clear to zero (priority over en)
//   en         : count enable; the count stops at FIN and never wraps
//   tc         : high while the count equals FIN
module contador_retardo #(
    parameter int ANCHO = 4,
    parameter int FIN   = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [ANCHO-1:0] FIN_V = ANCHO'(FIN);

    logic [ANCHO-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + ANCHO'(1);
        end
    end

    assign tc = (cnt == FIN_V);

endmodule

// File: rtl/alarma_temporizada.sv
// Timed vehicle alarm controller.
// Raises sAlr when the light is on, a door is open and ignition is off,
// after the trigger condition has held for RETARDO consecutive edges.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : alarma_temporizada_if.slave (sLuz, sPrta, sIgn, sAck in;
//           sAlr, sPrtaCap, estado out, all outputs registered)
// Build option: define ALARMA_PARPADEO_EN to make sAlr blink in ALARMA with
// a half-period of PARPADEO cycles; otherwise sAlr is steady and PARPADEO
// is unused.
module alarma_temporizada
    import alarma_pkg::*;
#(
    parameter int N_PUERTAS = 4,
    parameter int RETARDO   = 8,
    parameter int PARPADEO  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    alarma_temporizada_if.slave  bus
);

    localparam int ANCHO_CNT = $clog2(RETARDO + 2);

    if (N_PUERTAS < 1 || RETARDO < 0 || PARPADEO < 1) begin : gParamCheck
        $error("alarma_temporizada: invalid parameter value");
    end

    estado_t              estadoQ;
    estado_t              estadoD;
    logic                 sAlrQ;
    logic [N_PUERTAS-1:0] capQ;
    logic                 cond;
    logic                 tcRet;
    logic                 entrada;

    assign cond = bus.sLuz & (|bus.sPrta) & ~bus.sIgn;

    // Counter is held at zero outside ESPERA and on any low sample, so each
    // low sample restarts the full delay.
    contador_retardo #(
        .ANCHO (ANCHO_CNT),
        .FIN   ((RETARDO == 0) ? 0 : RETARDO - 1)
    ) uRetardo (
        .clk   (clk),
        .reset (reset),
        .clr   ((estadoQ != ESPERA) || !cond),
        .en    ((estadoQ == ESPERA) && cond),
        .tc    (tcRet)
    );

    always_comb begin
        estadoD = estadoQ;
        unique case (estadoQ)
            REPOSO:   if (cond) estadoD = (RETARDO == 0) ? ALARMA : ESPERA;
            ESPERA:   if (!cond) estadoD = REPOSO;
                      else if (tcRet) estadoD = ALARMA;
            ALARMA:   if (!cond) estadoD = REPOSO;
                      else if (bus.sAck) estadoD = SILENCIO;
            SILENCIO: if (!cond) estadoD = REPOSO;
            default:  estadoD = REPOSO;
        endcase
    end

    assign entrada = (estadoD == ALARMA) && (estadoQ != ALARMA);

`ifdef ALARMA_PARPADEO_EN
    logic tcPar;

    // Blink counter restarts on ALARMA entry and after every toggle.
    contador_retardo #(
        .ANCHO ($clog2(PARPADEO + 1)),
        .FIN   (PARPADEO - 1)
    ) uParpadeo (
        .clk   (clk),
        .reset (reset),
        .clr   ((estadoQ != ALARMA) || (estadoD != ALARMA) || tcPar),
        .en    (1'b1),
        .tc    (tcPar)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            estadoQ <= REPOSO;
            sAlrQ   <= 1'b0;
            capQ    <= '0;
        end else begin
            estadoQ <= estadoD;
            if (entrada) begin
                capQ <= bus.sPrta;
            end
`ifdef ALARMA_PARPADEO_EN
            if (entrada) begin
                sAlrQ <= 1'b1;
            end else if (estadoD == ALARMA) begin
                sAlrQ <= tcPar ? ~sAlrQ : sAlrQ;
            end else begin
                sAlrQ <= 1'b0;
            end
`else
            sAlrQ <= (estadoD == ALARMA);
`endif
        end
    end

    assign bus.estado   = estadoQ;
    assign bus.sAlr     = sAlrQ;
    assign bus.sPrtaCap = capQ;

endmodule

// File: tb/tb_alarma_temporizada.sv
module tb_alarma_temporizada;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alarma_temporizada_if #(.N_PUERTAS(4)) bus ();
    alarma_temporizada_if #(.N_PUERTAS(4)) bus0 ();

    alarma_temporizada #(.N_PUERTAS(4), .RETARDO(8), .PARPADEO(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    alarma_temporizada #(.N_PUERTAS(4), .RETARDO(0), .PARPADEO(4)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.sLuz = 1'b1; bus.sPrta = 4'b1111; bus.sIgn = 1'b0; bus.sAck = 1'b0;
        bus0.sLuz = 1'b1; bus0.sPrta = 4'b1111; bus0.sIgn = 1'b0; bus0.sAck = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (bus.estado !== 2'd0) begin bad++; $display("FAIL reset_estado got=%0d want=0", bus.estado); end
        total++;
        if (bus.sAlr !== 1'b0) begin bad++; $display("FAIL reset_sAlr got=%b want=0", bus.sAlr); end
        total++;
        if (bus.sPrtaCap !== 4'b0000) begin bad++; $display("FAIL reset_cap got=%b want=0000", bus.sPrtaCap); end
        total++;
        if (bus0.estado !== 2'd0 || bus0.sAlr !== 1'b0) begin
            bad++; $display("FAIL reset_dut0 got estado=%0d sAlr=%b want 0/0", bus0.estado, bus0.sAlr);
        end
        bus.sLuz = 1'b0; bus.sPrta = 4'b0000;
        bus0.sLuz = 1'b0; bus0.sPrta = 4'b0000;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_delay;
        bus.sLuz = 1'b1; bus.sPrta = 4'b0010; bus.sIgn = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            // acknowledge outside ALARMA must have no effect
            bus.sAck = (e <= 6);
            tick();
            total++;
            if (bus.sAlr !== (e == 8)) begin
                bad++; $display("FAIL delay_sAlr edge=%0d got=%b want=%b", e, bus.sAlr, (e == 8));
            end
            if (e == 0) begin
                total++;
                if (bus.estado !== 2'd1) begin bad++; $display("FAIL delay_espera got=%0d want=1", bus.estado); end
            end
        end
        total++;
        if (bus.estado !== 2'd2) begin bad++; $display("FAIL delay_estado got=%0d want=2", bus.estado); end
        total++;
        if (bus.sPrtaCap !== 4'b0010) begin bad++; $display("FAIL delay_cap got=%b want=0010", bus.sPrtaCap); end
    endtask

    task automatic test_ack;
        bus.sAck = 1'b1;
        tick();
        total++;
        if (bus.estado !== 2'd3 || bus.sAlr !== 1'b0) begin
            bad++; $display("FAIL ack_silencio got estado=%0d sAlr=%b want 3/0", bus.estado, bus.sAlr);
        end
        bus.sAck = 1'b0;
        bus.sPrta = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.estado !== 2'd3 || bus.sAlr !== 1'b0) begin
                bad++; $display("FAIL ack_hold cyc=%0d got estado=%0d sAlr=%b want 3/0", i, bus.estado, bus.sAlr);
            end
        end
        total++;
        if (bus.sPrtaCap !== 4'b0010) begin bad++; $display("FAIL ack_cap got=%b want=0010", bus.sPrtaCap); end
        bus.sIgn = 1'b1;
        tick();
        total++;
        if (bus.estado !== 2'd0) begin bad++; $display("FAIL ack_exit got=%0d want=0", bus.estado); end
    endtask

    task automatic test_glitch;
        bus.sIgn = 1'b0; bus.sAck = 1'b0; bus.sPrta = 4'b0001;
        for (int e = 0; e <= 14; e++) begin
            bus.sLuz = (e != 5);
            tick();
            total++;
            if (bus.sAlr !== (e == 14)) begin
                bad++; $display("FAIL glitch_sAlr edge=%0d got=%b want=%b", e, bus.sAlr, (e == 14));
            end
            if (e == 5) begin
                total++;
                if (bus.estado !== 2'd0) begin bad++; $display("FAIL glitch_reposo got=%0d want=0", bus.estado); end
            end
        end
        total++;
        if (bus.estado !== 2'd2 || bus.sPrtaCap !== 4'b0001) begin
            bad++; $display("FAIL glitch_end got estado=%0d cap=%b want 2/0001", bus.estado, bus.sPrtaCap);
        end
    endtask

    task automatic test_simultaneous;
        bus.sAck = 1'b1; bus.sIgn = 1'b1;
        tick();
        total++;
        if (bus.estado !== 2'd0 || bus.sAlr !== 1'b0) begin
            bad++; $display("FAIL simult got estado=%0d sAlr=%b want 0/0", bus.estado, bus.sAlr);
        end
        bus.sAck = 1'b0; bus.sIgn = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n;
        bus.sLuz = 1'b1; bus.sPrta = 4'b0100; bus.sIgn = 1'b0; bus.sAck = 1'b0;
        n = 0;
        while (bus.sAlr !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (bus.sAlr !== 1'b1 || n != 9) begin
            bad++; $display("FAIL rstmid_reach got sAlr=%b cycles=%0d want 1/9", bus.sAlr, n);
        end
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (bus.estado !== 2'd0 || bus.sAlr !== 1'b0 || bus.sPrtaCap !== 4'b0000) begin
            bad++; $display("FAIL rstmid got estado=%0d sAlr=%b cap=%b want 0/0/0000",
                            bus.estado, bus.sAlr, bus.sPrtaCap);
        end
        reset = 1'b0;
        bus.sLuz = 1'b0; bus.sPrta = 4'b0000;
        tick();
    endtask

    task automatic test_retardo0;
        logic want;
        bus0.sLuz = 1'b1; bus0.sPrta = 4'b0100; bus0.sIgn = 1'b0; bus0.sAck = 1'b0;
        tick();
        total++;
        if (bus0.sAlr !== 1'b1 || bus0.estado !== 2'd2 || bus0.sPrtaCap !== 4'b0100) begin
            bad++; $display("FAIL r0_entry got sAlr=%b estado=%0d cap=%b want 1/2/0100",
                            bus0.sAlr, bus0.estado, bus0.sPrtaCap);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
`ifdef ALARMA_PARPADEO_EN
            want = (((i / 4) % 2) == 0);
`else
            want = 1'b1;
`endif
            total++;
            if (bus0.sAlr !== want) begin
                bad++; $display("FAIL r0_hold cyc=%0d got=%b want=%b", i, bus0.sAlr, want);
            end
        end
        bus0.sLuz = 1'b0;
        tick();
        total++;
        if (bus0.estado !== 2'd0 || bus0.sAlr !== 1'b0) begin
            bad++; $display("FAIL r0_exit got estado=%0d sAlr=%b want 0/0", bus0.estado, bus0.sAlr);
        end
    endtask

    initial begin
        test_reset();
        test_delay();
        test_ack();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_retardo0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
